// File: rtl/proc_pkg.sv
// Shared encodings for the run-control unit: host command opcodes,
// controller state encoding and a width helper.
package proc_pkg;

   localparam logic [2:0] CMD_RUN     = 3'd0;
   localparam logic [2:0] CMD_STEP    = 3'd1;
   localparam logic [2:0] CMD_HALT    = 3'd2;
   localparam logic [2:0] CMD_SET_BP  = 3'd3;
   localparam logic [2:0] CMD_CLR_BP  = 3'd4;
   localparam logic [2:0] CMD_DUMP    = 3'd5;
   localparam logic [2:0] CMD_RESTART = 3'd6;

   typedef enum logic [2:0] {
      ST_RST_HOLD = 3'd0,
      ST_RUN      = 3'd1,
      ST_STEP     = 3'd2,
      ST_HALT     = 3'd3,
      ST_DUMP     = 3'd4
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Host/core bundle of the run-control unit.
// With RUN_CTRL_WATCHDOG_EN defined the bundle also carries wdog_hit.
interface run_ctrl_if
   import proc_pkg::*;
#(
   parameter int PC_W     = 16,
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int NUM_BP   = 2,
   parameter int CNT_W    = 32
);
   localparam int IDX_W = clog2_min1(NUM_BP);
   localparam int RA_W  = clog2_min1(NUM_REGS);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [IDX_W-1:0]  cmd_idx;
   logic [PC_W-1:0]   cmd_addr;
   logic [PC_W-1:0]   pc;
   logic              cpu_rst;
   logic              cpu_en;
   logic [RA_W-1:0]   rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [RA_W-1:0]   dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic              halted;
   logic              bp_hit;
   logic [IDX_W-1:0]  bp_hit_idx;
   logic              cmd_err;
   logic [CNT_W-1:0]  cycle_cnt;
`ifdef RUN_CTRL_WATCHDOG_EN
   logic              wdog_hit;
`endif

   modport master (
      output cmd_valid, cmd_op, cmd_idx, cmd_addr, pc, rf_data, dump_ready,
      input  cmd_ready, cpu_rst, cpu_en, rf_addr, dump_valid, dump_idx,
             dump_data, halted, bp_hit, bp_hit_idx, cmd_err, cycle_cnt
`ifdef RUN_CTRL_WATCHDOG_EN
             , wdog_hit
`endif
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_idx, cmd_addr, pc, rf_data, dump_ready,
      output cmd_ready, cpu_rst, cpu_en, rf_addr, dump_valid, dump_idx,
             dump_data, halted, bp_hit, bp_hit_idx, cmd_err, cycle_cnt
`ifdef RUN_CTRL_WATCHDOG_EN
             , wdog_hit
`endif
   );

endinterface

// File: rtl/run_ctrl_bp_match_unit.sv
// Breakpoint address/enable registers with a combinational PC compare
// that reports the lowest matching breakpoint index.
module bp_match_unit
   import proc_pkg::*;
#(
   parameter int PC_W   = 16,
   parameter int NUM_BP = 2,
   parameter int IDX_W  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_set,
   input  logic             i_clr,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [PC_W-1:0]  i_addr,
   input  logic [PC_W-1:0]  i_pc,
   output logic             o_match,
   output logic [IDX_W-1:0] o_idx
);

   logic [PC_W-1:0]   r_addr [NUM_BP];
   logic [NUM_BP-1:0] r_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BP; i++) r_addr[i] <= '0;
         r_en <= '0;
      end else begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (i_set && i_idx == IDX_W'(i)) begin
               r_addr[i] <= i_addr;
               r_en[i]   <= 1'b1;
            end else if (i_clr && i_idx == IDX_W'(i)) begin
               r_en[i]   <= 1'b0;
            end
         end
      end
   end

   // Scan high to low so the lowest matching index wins.
   always_comb begin
      o_match = 1'b0;
      o_idx   = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (r_en[i] && r_addr[i] == i_pc) begin
            o_match = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run-control unit: core reset/clock-enable, breakpoints, stepping, register dump.
// Optional watchdog halt when RUN_CTRL_WATCHDOG_EN is defined.
module run_ctrl
   import proc_pkg::*;
#(
`ifdef RUN_CTRL_WATCHDOG_EN
   parameter int WDOG_CYCLES = 1024,
`endif
   parameter int PC_W       = 16,
   parameter int DATA_W     = 16,
   parameter int NUM_REGS   = 8,
   parameter int NUM_BP     = 2,
   parameter int RST_CYCLES = 2,
   parameter int CNT_W      = 32,
   parameter int AUTO_RUN   = 1
) (
   input logic       clk,
   input logic       reset,
   run_ctrl_if.slave bus
);

   localparam int IDX_W = clog2_min1(NUM_BP);
   localparam int RA_W  = clog2_min1(NUM_REGS);
   localparam int HC_W  = clog2_min1(RST_CYCLES + 1);
   localparam logic [RA_W-1:0] LAST_REG  = RA_W'(NUM_REGS - 1);
   localparam logic [HC_W-1:0] LAST_HOLD = HC_W'(RST_CYCLES - 1);
   localparam state_t AFTER_HOLD = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;

   state_t           r_state;
   logic [HC_W-1:0]  r_hold;
   logic             r_skip;
   logic             r_bp_hit;
   logic [IDX_W-1:0] r_bp_idx;
   logic             r_cmd_err;
   logic [CNT_W-1:0] r_cnt;
   logic [RA_W-1:0]  r_rf_addr;

   logic             w_ready;
   logic             w_acc;
   logic             w_halt_cmd;
   logic             w_bp_match;
   logic [IDX_W-1:0] w_bp_idx;
   logic             w_bp_halt;
   logic             w_cpu_en;

   assign w_ready    = (r_state == ST_RUN) || (r_state == ST_STEP) ||
                       (r_state == ST_HALT);
   assign w_acc      = bus.cmd_valid && w_ready;
   assign w_halt_cmd = w_acc && (bus.cmd_op == CMD_HALT);
   assign w_bp_halt  = (r_state == ST_RUN) && w_bp_match && !r_skip;
   assign w_cpu_en   = (r_state == ST_STEP) ||
                       ((r_state == ST_RUN) && !w_bp_halt && !w_halt_cmd);

   bp_match_unit #(
      .PC_W  (PC_W),
      .NUM_BP(NUM_BP),
      .IDX_W (IDX_W)
   ) u_bp (
      .clk    (clk),
      .rst    (reset),
      .i_set  (w_acc && bus.cmd_op == CMD_SET_BP),
      .i_clr  (w_acc && bus.cmd_op == CMD_CLR_BP),
      .i_idx  (bus.cmd_idx),
      .i_addr (bus.cmd_addr),
      .i_pc   (bus.pc),
      .o_match(w_bp_match),
      .o_idx  (w_bp_idx)
   );

`ifdef RUN_CTRL_WATCHDOG_EN
   logic [31:0] r_wdog;
   logic        r_wdog_hit;
   assign bus.wdog_hit = r_wdog_hit;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_RST_HOLD;
         r_hold    <= '0;
         r_skip    <= 1'b0;
         r_bp_hit  <= 1'b0;
         r_bp_idx  <= '0;
         r_cmd_err <= 1'b0;
         r_cnt     <= '0;
         r_rf_addr <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
         r_wdog     <= '0;
         r_wdog_hit <= 1'b0;
`endif
      end else begin
         r_cmd_err <= 1'b0;
         r_skip    <= 1'b0;
         if (w_cpu_en && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
`ifdef RUN_CTRL_WATCHDOG_EN
         r_wdog <= (r_state == ST_RUN) ? r_wdog + 32'd1 : 32'd0;
`endif
         unique case (r_state)
            ST_RST_HOLD: begin
               if (r_hold == LAST_HOLD) begin
                  r_hold  <= '0;
                  r_state <= AFTER_HOLD;
               end else begin
                  r_hold  <= r_hold + HC_W'(1);
               end
            end
            ST_RUN: begin
               if (w_bp_halt) begin
                  r_state  <= ST_HALT;
                  r_bp_hit <= 1'b1;
                  r_bp_idx <= w_bp_idx;
               end
`ifdef RUN_CTRL_WATCHDOG_EN
               else if (r_wdog == 32'(WDOG_CYCLES - 1)) begin
                  r_state    <= ST_HALT;
                  r_bp_hit   <= 1'b0;
                  r_wdog_hit <= 1'b1;
               end
`endif
            end
            ST_STEP: begin
               r_state  <= ST_HALT;
               r_bp_hit <= 1'b0;
            end
            ST_DUMP: begin
               if (bus.dump_ready) begin
                  if (r_rf_addr == LAST_REG) r_state <= ST_HALT;
                  else r_rf_addr <= r_rf_addr + RA_W'(1);
               end
            end
            default: ;
         endcase
         // Accepted commands override the state-driven transition above.
         if (w_acc) begin
            unique case (bus.cmd_op)
               CMD_RUN: begin
                  if (r_state == ST_HALT) begin
                     r_state <= ST_RUN;
                     r_skip  <= 1'b1;
`ifdef RUN_CTRL_WATCHDOG_EN
                     r_wdog_hit <= 1'b0;
`endif
                  end else r_cmd_err <= 1'b1;
               end
               CMD_STEP: begin
                  if (r_state == ST_HALT) begin
                     r_state <= ST_STEP;
`ifdef RUN_CTRL_WATCHDOG_EN
                     r_wdog_hit <= 1'b0;
`endif
                  end else r_cmd_err <= 1'b1;
               end
               CMD_HALT: begin
                  if (r_state == ST_RUN) begin
                     r_state  <= ST_HALT;
                     r_bp_hit <= 1'b0;
                  end else r_cmd_err <= 1'b1;
               end
               CMD_DUMP: begin
                  if (r_state == ST_HALT) begin
                     r_state   <= ST_DUMP;
                     r_rf_addr <= '0;
                  end else r_cmd_err <= 1'b1;
               end
               CMD_RESTART: begin
                  r_state <= ST_RST_HOLD;
                  r_hold  <= '0;
                  r_cnt   <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
                  r_wdog_hit <= 1'b0;
`endif
               end
               CMD_SET_BP, CMD_CLR_BP: ;
               default: r_cmd_err <= 1'b1;
            endcase
         end
      end
   end

   assign bus.cmd_ready  = w_ready;
   assign bus.cpu_rst    = (r_state == ST_RST_HOLD);
   assign bus.cpu_en     = w_cpu_en;
   assign bus.rf_addr    = r_rf_addr;
   assign bus.dump_valid = (r_state == ST_DUMP);
   assign bus.dump_idx   = r_rf_addr;
   assign bus.dump_data  = bus.rf_data;
   assign bus.halted     = (r_state == ST_HALT);
   assign bus.bp_hit     = r_bp_hit;
   assign bus.bp_hit_idx = r_bp_idx;
   assign bus.cmd_err    = r_cmd_err;
   assign bus.cycle_cnt  = r_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a counting core model and a fixed register file.
module tb_run_ctrl;
   import proc_pkg::*;

   logic clk;
   logic reset;
   logic [15:0] pc;
   logic [15:0] rf [8];
   int checks;
   int failures;

   run_ctrl_if bus ();

   run_ctrl u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.cpu_rst) pc <= 16'd0;
      else if (bus.cpu_en) pc <= pc + 16'd1;
   end

   assign bus.pc      = pc;
   assign bus.rf_data = rf[bus.rf_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [2:0] op, input logic idx,
                      input logic [15:0] addr);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_idx   = idx;
      bus.cmd_addr  = addr;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      logic [2:0]  pat;
      logic [15:0] hold_data;
      logic        stalled;
      int          exp_i;
      checks = 0;
      failures = 0;
      pat = 3'b101;
      for (int i = 0; i < 8; i++) rf[i] = 16'hA000 + 16'(i) * 16'h0111;
      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 3'd0;
      bus.cmd_idx = 1'b0;
      bus.cmd_addr = 16'd0;
      bus.dump_ready = 1'b0;
      tick();
      tick();
      check("rst_cpu_rst", bus.cpu_rst, 1);
      check("rst_cpu_en", bus.cpu_en, 0);
      check("rst_ready", bus.cmd_ready, 0);
      check("rst_dvalid", bus.dump_valid, 0);
      check("rst_halted", bus.halted, 0);
      check("rst_bp_hit", bus.bp_hit, 0);
      check("rst_err", bus.cmd_err, 0);
      check("rst_cnt", bus.cycle_cnt, 0);

      // Reset hold, then auto-run from pc 0.
      reset = 1'b0;
      tick();
      check("hold1_cpu_rst", bus.cpu_rst, 1);
      tick();
      check("hold2_cpu_rst", bus.cpu_rst, 0);
      check("run_cpu_en", bus.cpu_en, 1);
      check("run_pc0", pc, 0);
      tick();
      check("run_pc1", pc, 1);
      check("run_cnt1", bus.cycle_cnt, 1);

      // Breakpoint at 5, restart, halt on it.
      cmd(CMD_SET_BP, 1'b0, 16'd5);
      cmd(CMD_RESTART, 1'b0, 16'd0);
      check("restart_cpu_rst", bus.cpu_rst, 1);
      check("restart_cnt", bus.cycle_cnt, 0);
      for (int k = 0; k < 40 && !bus.halted; k++) tick();
      check("bp_halted", bus.halted, 1);
      check("bp_hit", bus.bp_hit, 1);
      check("bp_hit_idx", bus.bp_hit_idx, 0);
      check("bp_pc", pc, 5);
      check("bp_cnt", bus.cycle_cnt, 5);
      check("bp_cpu_en", bus.cpu_en, 0);
      check("halt_ready", bus.cmd_ready, 1);

      // Resume executes the breakpoint instruction.
      cmd(CMD_RUN, 1'b0, 16'd0);
      check("resume_cpu_en", bus.cpu_en, 1);
      tick();
      check("resume_pc", pc, 6);
      check("resume_running", bus.halted, 0);

      // Restart, halt at pc 3, then single steps.
      cmd(CMD_RESTART, 1'b0, 16'd0);
      for (int k = 0; k < 20 && pc != 16'd3; k++) tick();
      check("pre_halt_pc", pc, 3);
      cmd(CMD_HALT, 1'b0, 16'd0);
      check("halt_halted", bus.halted, 1);
      check("halt_pc", pc, 3);
      check("halt_bp_hit", bus.bp_hit, 0);
      check("halt_cnt", bus.cycle_cnt, 3);
      for (int s = 0; s < 3; s++) begin
         cmd(CMD_STEP, 1'b0, 16'd0);
         check("step_cpu_en", bus.cpu_en, 1);
         tick();
         check("step_halted", bus.halted, 1);
         check("step_cpu_en_off", bus.cpu_en, 0);
         check("step_pc", pc, 64'(4 + s));
         check("step_bp_hit", bus.bp_hit, 0);
      end
      check("step_cnt", bus.cycle_cnt, 6);

      // Register dump with stalls.
      cmd(CMD_DUMP, 1'b0, 16'd0);
      check("dump_ready_low", bus.cmd_ready, 0);
      exp_i = 0;
      stalled = 1'b0;
      hold_data = 16'd0;
      for (int k = 0; k < 40 && exp_i < 8; k++) begin
         bus.dump_ready = pat[k % 3];
         check("dump_valid", bus.dump_valid, 1);
         check("dump_idx", bus.dump_idx, 64'(exp_i));
         check("dump_data", bus.dump_data, rf[exp_i]);
         if (stalled) check("dump_hold", bus.dump_data, hold_data);
         stalled = !bus.dump_ready;
         hold_data = bus.dump_data;
         tick();
         if (bus.dump_ready) exp_i++;
      end
      bus.dump_ready = 1'b0;
      check("dump_beats", 64'(exp_i), 8);
      check("dump_done_halted", bus.halted, 1);
      check("dump_done_valid", bus.dump_valid, 0);

      // Illegal RUN while running.
      cmd(CMD_RUN, 1'b0, 16'd0);
      tick();
      cmd(CMD_RUN, 1'b0, 16'd0);
      check("err_pulse", bus.cmd_err, 1);
      check("err_running", bus.halted, 0);
      check("err_cpu_en", bus.cpu_en, 1);
      tick();
      check("err_clear", bus.cmd_err, 0);

      // Reset in the middle of a dump.
      cmd(CMD_HALT, 1'b0, 16'd0);
      cmd(CMD_DUMP, 1'b0, 16'd0);
      tick();
      check("mid_dump_valid", bus.dump_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_cpu_rst", bus.cpu_rst, 1);
      check("mid_rst_dvalid", bus.dump_valid, 0);
      check("mid_rst_halted", bus.halted, 0);
      check("mid_rst_cnt", bus.cycle_cnt, 0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 8; k++) tick();
      check("bp_cleared_pc", pc, 8);
      check("bp_cleared_run", bus.halted, 0);

      // Breakpoint on index 1.
      cmd(CMD_SET_BP, 1'b1, 16'd12);
      for (int k = 0; k < 20 && !bus.halted; k++) tick();
      check("bp1_halted", bus.halted, 1);
      check("bp1_pc", pc, 12);
      check("bp1_idx", bus.bp_hit_idx, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
